pipelined_adder: RTL and testbench

Parametrised, pipelined successor to the fixed 11-bit ripple-carry adder. Splits a WIDTH-bit carry chain into CHUNK-bit registered segments so that wide additions close timing. Adds a subtract mode, a signed-overflow flag and valid/ready handshaking on both sides. Sits in the datapath wherever the combinational adder is too slow or the producer and consumer need flow control.

---
 rtl/pipelined_adder_if.sv | 26 ++
 rtl/pipelined_adder.sv | 86 ++++++++
 tb/tb_pipelined_adder.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The slave modport is the adder's view; master is the producer/consumer side.
`timescale 1ns / 1ps
interface pipelined_adder_if #(
  parameter int unsigned WIDTH = 11
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: the WIDTH-bit carry chain is cut into CHUNK-bit registered
// segments, with a single global advance enable for valid/ready flow control.
`timescale 1ns / 1ps
module pipelined_adder #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned CHUNK = 4
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_adder_if.slave bus
);
  localparam int unsigned STAGES = (WIDTH + CHUNK - 1) / CHUNK;

  logic adv;

  // Whole pipe moves or whole pipe holds; bubbles are not squeezed out.
  assign adv = ~g_stage[STAGES-1].v_q | bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * CHUNK;
    localparam int unsigned SW = ((WIDTH - LO) < CHUNK) ? (WIDTH - LO) : CHUNK;

    logic             v_in;
    logic             c_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] bp_in;
    logic [WIDTH-1:0] r_in;
    logic [WIDTH-1:0] r_d;
    logic [SW:0]      seg;
    logic             ovf_d;

    logic             v_q;
    logic             c_q;
    logic             ovf_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] bp_q;
    logic [WIDTH-1:0] r_q;

    if (k == 0) begin : g_head
      assign v_in  = bus.in_valid;
      assign a_in  = bus.a;
      assign bp_in = bus.sub ? ~bus.b : bus.b;
      assign r_in  = '0;
      assign c_in  = bus.sub;
    end else begin : g_body
      assign v_in  = g_stage[k-1].v_q;
      assign a_in  = g_stage[k-1].a_q;
      assign bp_in = g_stage[k-1].bp_q;
      assign r_in  = g_stage[k-1].r_q;
      assign c_in  = g_stage[k-1].c_q;
    end

    assign seg = {1'b0, a_in[LO +: SW]} + {1'b0, bp_in[LO +: SW]} + {{SW{1'b0}}, c_in};

    always_comb begin
      r_d           = r_in;
      r_d[LO +: SW] = seg[SW-1:0];
    end

    // Carry into the MSB is recovered from the MSB sum bit; only meaningful in the last stage.
    assign ovf_d = (a_in[WIDTH-1] ^ bp_in[WIDTH-1] ^ r_d[WIDTH-1]) ^ seg[SW];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        ovf_q <= 1'b0;
        a_q   <= '0;
        bp_q  <= '0;
        r_q   <= '0;
      end else if (adv) begin
        v_q   <= v_in;
        c_q   <= seg[SW];
        ovf_q <= ovf_d;
        a_q   <= a_in;
        bp_q  <= bp_in;
        r_q   <= r_d;
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = g_stage[STAGES-1].v_q;
  assign bus.sum       = {g_stage[STAGES-1].c_q, g_stage[STAGES-1].r_q};
  assign bus.ovf       = g_stage[STAGES-1].ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Randomized and directed bench for pipelined_adder; four geometries share one stimulus
// stream and each is scored against an integer-arithmetic reference.
`timescale 1ns / 1ps
module tb_pipelined_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(11)) bus_a ();
  pipelined_adder_if #(.WIDTH(11)) bus_c1 ();
  pipelined_adder_if #(.WIDTH(11)) bus_c11 ();
  pipelined_adder_if #(.WIDTH(32)) bus_w ();

  assign bus_a.in_valid   = in_valid;
  assign bus_a.out_ready  = out_ready;
  assign bus_a.a          = a32[10:0];
  assign bus_a.b          = b32[10:0];
  assign bus_a.sub        = sub;
  assign bus_c1.in_valid  = in_valid;
  assign bus_c1.out_ready = out_ready;
  assign bus_c1.a         = a32[10:0];
  assign bus_c1.b         = b32[10:0];
  assign bus_c1.sub       = sub;
  assign bus_c11.in_valid  = in_valid;
  assign bus_c11.out_ready = out_ready;
  assign bus_c11.a         = a32[10:0];
  assign bus_c11.b         = b32[10:0];
  assign bus_c11.sub       = sub;
  assign bus_w.in_valid   = in_valid;
  assign bus_w.out_ready  = out_ready;
  assign bus_w.a          = a32;
  assign bus_w.b          = b32;
  assign bus_w.sub        = sub;

  pipelined_adder #(.WIDTH(11), .CHUNK(4)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  pipelined_adder #(.WIDTH(11), .CHUNK(1)) u_c1 (.clk(clk), .rst_n(rst_n), .bus(bus_c1));
  pipelined_adder #(.WIDTH(11), .CHUNK(11)) u_c11 (.clk(clk), .rst_n(rst_n), .bus(bus_c11));
  pipelined_adder #(.WIDTH(32), .CHUNK(8)) u_w32 (.clk(clk), .rst_n(rst_n), .bus(bus_w));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf at bit 40, carry at bit w, w-bit result} from plain integer arithmetic.
  function automatic logic [63:0] model(input int unsigned w, input logic [31:0] a,
                                        input logic [31:0] b, input logic s);
    longint m, ua, ub, sa, sb, sr, raw;
    logic   carry, ovf;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (s) begin
      raw   = (ua + m - ub) % m;
      carry = (ua >= ub);
      sr    = sa - sb;
    end else begin
      raw   = (ua + ub) % m;
      carry = ((ua + ub) >= m);
      sr    = sa + sb;
    end
    ovf = (sr < -(m / 2)) || (sr >= m / 2);
    return (64'(ovf) << 40) | (64'(carry) << w) | 64'(raw);
  endfunction

  function automatic logic [63:0] pack_obs(input logic [32:0] sm, input logic ov);
    return (64'(ov) << 40) | 64'(sm);
  endfunction

  logic [63:0] exp_q[4][$];

  task automatic mon(input int idx, input int unsigned w, input logic in_fire,
                     input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic out_fire, input logic [32:0] sm, input logic ov);
    logic [63:0] exp;
    if (out_fire) begin
      if (exp_q[idx].size() == 0) begin
        check_eq($sformatf("unexpected_out[%0d]", idx), 64'(out_fire), 64'd0);
      end else begin
        exp = exp_q[idx].pop_front();
        check_eq($sformatf("result[%0d]", idx), pack_obs(sm, ov), exp);
      end
    end
    if (in_fire) exp_q[idx].push_back(model(w, a, b, s));
  endtask

  // Transfers are sampled mid-cycle; they take effect at the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, 11, bus_a.in_valid & bus_a.in_ready, 32'(bus_a.a), 32'(bus_a.b), bus_a.sub,
          bus_a.out_valid & bus_a.out_ready, 33'(bus_a.sum), bus_a.ovf);
      mon(1, 11, bus_c1.in_valid & bus_c1.in_ready, 32'(bus_c1.a), 32'(bus_c1.b), bus_c1.sub,
          bus_c1.out_valid & bus_c1.out_ready, 33'(bus_c1.sum), bus_c1.ovf);
      mon(2, 11, bus_c11.in_valid & bus_c11.in_ready, 32'(bus_c11.a), 32'(bus_c11.b),
          bus_c11.sub, bus_c11.out_valid & bus_c11.out_ready, 33'(bus_c11.sum), bus_c11.ovf);
      mon(3, 32, bus_w.in_valid & bus_w.in_ready, bus_w.a, bus_w.b, bus_w.sub,
          bus_w.out_valid & bus_w.out_ready, 33'(bus_w.sum), bus_w.ovf);
    end
  end

  always @(negedge rst_n) begin
    for (int i = 0; i < 4; i++) exp_q[i].delete();
  end

  task automatic run_one(input string tag, input logic [10:0] a, input logic [10:0] b,
                         input logic s, input logic [11:0] exp_sum, input logic exp_ovf);
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    a32       = 32'(a);
    b32       = 32'(b);
    sub       = s;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check_eq({tag, "_valid"}, 64'(bus_a.out_valid), 64'(i == 3));
    end
    check_eq({tag, "_sum"}, 64'(bus_a.sum), 64'(exp_sum));
    check_eq({tag, "_ovf"}, 64'(bus_a.ovf), 64'(exp_ovf));
  endtask

  logic [31:0] opa[4];
  logic [31:0] opb[4];
  logic        ops[4];
  int          acc;
  int          cyc;
  logic        fire;

  initial begin
    #2;
    check_eq("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check_eq("rst_sum", 64'(bus_a.sum), 64'd0);
    check_eq("rst_ovf", 64'(bus_a.ovf), 64'd0);
    check_eq("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
    #6;
    rst_n = 1'b1;

    run_one("umax", 11'h7FF, 11'h7FF, 1'b0, 12'hFFE, 1'b0);
    run_one("borrow", 11'd5, 11'd7, 1'b1, 12'h7FE, 1'b0);
    run_one("noborrow", 11'd7, 11'd5, 1'b1, 12'h802, 1'b0);
    run_one("ovf_add", 11'h3FF, 11'h001, 1'b0, 12'h400, 1'b1);
    run_one("ovf_sub", 11'h400, 11'h001, 1'b1, 12'hBFF, 1'b1);

    // Back-to-back streaming: one result every cycle once the pipe fills.
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      a32      = $urandom;
      b32      = $urandom;
      sub      = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("stream_in_ready", 64'(bus_a.in_ready), 64'd1);
      if (i >= 3) check_eq("stream_out_valid", 64'(bus_a.out_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    // Backpressure: three operands fill the pipe, the fourth waits.
    for (int i = 0; i < 4; i++) begin
      opa[i] = $urandom;
      opb[i] = $urandom;
      ops[i] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a32 = opa[0];
    b32 = opb[0];
    sub = ops[0];
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      fire = bus_a.in_ready;
      @(posedge clk);
      #1;
      if (fire) begin
        acc++;
        if (acc < 4) begin
          a32 = opa[acc];
          b32 = opb[acc];
          sub = ops[acc];
        end
      end
    end
    check_eq("bp_accepted", 64'(acc), 64'd3);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq("bp_in_ready", 64'(bus_a.in_ready), 64'd0);
      check_eq("bp_out_valid", 64'(bus_a.out_valid), 64'd1);
      check_eq("bp_hold", pack_obs(33'(bus_a.sum), bus_a.ovf), model(11, opa[0], opb[0], ops[0]));
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 64'(bus_a.in_ready), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check_eq("bp_after_valid", 64'(bus_a.out_valid), 64'd1);
    check_eq("bp_after_op1", pack_obs(33'(bus_a.sum), bus_a.ovf), model(11, opa[1], opb[1], ops[1]));
    out_ready = 1'b1;
    for (int i = 2; i < 4; i++) begin
      @(negedge clk);
      check_eq("bp_drain_valid", 64'(bus_a.out_valid), 64'd1);
      check_eq("bp_drain_op", pack_obs(33'(bus_a.sum), bus_a.ovf), model(11, opa[i], opb[i], ops[i]));
    end
    @(negedge clk);
    check_eq("bp_empty", 64'(bus_a.out_valid), 64'd0);
    repeat (20) @(posedge clk);

    // Random flow control on both sides.
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      a32       = $urandom;
      b32       = $urandom;
      sub       = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && bus_a.in_ready) acc++;
      cyc++;
    end
    check_eq("rand_accepted", 64'(acc), 64'd1000);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) check_eq($sformatf("drain_left[%0d]", i), 64'(exp_q[i].size()), 64'd0);

    // Asynchronous reset with three transactions in flight.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a32 = $urandom;
      b32 = $urandom;
      sub = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_eq("pre_rst_valid", 64'(bus_a.out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(bus_a.out_valid), 64'd0);
    check_eq("mid_rst_sum", 64'(bus_a.sum), 64'd0);
    check_eq("mid_rst_ovf", 64'(bus_a.ovf), 64'd0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("post_rst_idle", 64'(bus_a.out_valid), 64'd0);
    end
    run_one("post_rst", 11'h123, 11'h456, 1'b0, 12'h579, 1'b0);
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
